// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// opcode constants, access size/sign and controller state encodings.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {
        SZ_B,
        SZ_BU,
        SZ_H,
        SZ_HU,
        SZ_W
    } acc_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } dm_state_e;

    // Unknown opcodes that still reach MEM with a read/write flag are word accesses.
    function automatic acc_size_e decode_size(input logic [5:0] op);
        acc_size_e sz;
        case (op)
            OP_LB, OP_SB: sz = SZ_B;
            OP_LBU:       sz = SZ_BU;
            OP_LH, OP_SH: sz = SZ_H;
            OP_LHU:       sz = SZ_HU;
            default:      sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] off);
        logic ok;
        case (sz)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~off[0];
            default:     ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_lane_fmt.sv
// Byte-lane formatting for the data-memory bus: store data replication and
// byte enables on the way out, load byte/halfword extraction and extension
// on the way back. Purely combinational.
module dmem_lane_fmt
    import mips_mem_pkg::*;
(
    input  acc_size_e   i_st_size,
    input  logic        i_st_we,
    input  logic [1:0]  i_st_offset,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_be,
    input  acc_size_e   i_ld_size,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: loads drive all enables and zero write data.
    always_comb begin
        o_st_wdata = '0;
        o_st_be    = 4'b1111;
        if (i_st_we) begin
            case (i_st_size)
                SZ_B, SZ_BU: begin
                    o_st_wdata = {4{i_st_data[7:0]}};
                    o_st_be    = 4'b0001 << i_st_offset;
                end
                SZ_H, SZ_HU: begin
                    o_st_wdata = {2{i_st_data[15:0]}};
                    o_st_be    = i_st_offset[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    o_st_wdata = i_st_data;
                    o_st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Load side: pick the addressed lane(s) and extend to 32 bits.
    always_comb begin
        case (i_ld_offset)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_offset[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_size)
            SZ_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   o_ld_data = {24'b0, w_byte};
            SZ_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            SZ_HU:   o_ld_data = {16'b0, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller. Converts the load/store sitting in the
// EX/MEM register into a req/ack bus transaction, stalls the pipeline until
// it completes, formats load data and reports misalignment and bus timeouts.
module mem_stage_dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_ALUOUT,
    input  logic [31:0] mem_RFRD2,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    dm_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    acc_size_e        r_ld_size;
    logic [1:0]       r_offset;
    logic             r_is_load;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;
    logic             r_misalign;
    logic             r_bus_err;

    logic             w_access;
    acc_size_e        w_size;
    logic             w_aligned;
    logic             w_start;
    logic [31:0]      w_st_wdata;
    logic [3:0]       w_st_be;
    logic [31:0]      w_ld_data;
    logic             w_unused_inst;

    assign w_access      = mem_MemRead | mem_MemWrite;
    assign w_size        = decode_size(mem_inst[31:26]);
    assign w_aligned     = is_aligned(w_size, mem_ALUOUT[1:0]);
    assign w_start       = (r_state == ST_IDLE) & w_access & w_aligned;
    assign w_unused_inst = ^mem_inst[25:0];

    // Stall covers the issuing IDLE cycle and every REQ cycle; DONE lets the pipe move.
    assign stall = w_start | (r_state == ST_REQ);

    dmem_lane_fmt u_fmt (
        .i_st_size   (w_size),
        .i_st_we     (mem_MemWrite),
        .i_st_offset (mem_ALUOUT[1:0]),
        .i_st_data   (mem_RFRD2),
        .o_st_wdata  (w_st_wdata),
        .o_st_be     (w_st_be),
        .i_ld_size   (r_ld_size),
        .i_ld_offset (r_offset),
        .i_ld_word   (dm_rdata),
        .o_ld_data   (w_ld_data)
    );

    // Controller FSM with registered bus signals and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ld_size  <= SZ_W;
            r_offset   <= '0;
            r_is_load  <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_addr    <= {mem_ALUOUT[31:2], 2'b00};
                            r_we      <= mem_MemWrite;
                            r_be      <= w_st_be;
                            r_wdata   <= w_st_wdata;
                            r_offset  <= mem_ALUOUT[1:0];
                            r_ld_size <= w_size;
                            r_is_load <= ~mem_MemWrite;
                            r_req     <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_REQ;
                        end else begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        r_req <= 1'b0;
                        if (r_is_load) begin
                            r_rd_data  <= w_ld_data;
                            r_rd_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign misalign = r_misalign;
    assign bus_err  = r_bus_err;
    assign dm_req   = r_req;
    assign dm_we    = r_we;
    assign dm_addr  = r_addr;
    assign dm_wdata = r_wdata;
    assign dm_be    = r_be;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed bench for mem_stage_dmem_ctrl: loads/stores with hand-computed
// bus and load-data values, misalignment, timeout and mid-transaction reset.
module tb_mem_stage_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_inst, mem_ALUOUT, mem_RFRD2;
    logic        mem_MemRead, mem_MemWrite;
    logic        stall, rd_valid, misalign, bus_err, dm_req, dm_we;
    logic [31:0] rd_data, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    // Second instance with a short timeout and a bus that never acknowledges.
    logic [31:0] t_inst, t_addr, t_wd;
    logic        t_rd, t_wr, t_ack;
    logic [31:0] t_rdata;
    logic        stall_t, rd_valid_t, misalign_t, bus_err_t, dm_req_t, dm_we_t;
    logic [31:0] rd_data_t, dm_addr_t, dm_wdata_t;
    logic [3:0]  dm_be_t;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_dmem_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_inst(mem_inst), .mem_ALUOUT(mem_ALUOUT), .mem_RFRD2(mem_RFRD2),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid),
        .misalign(misalign), .bus_err(bus_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    mem_stage_dmem_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut_t (
        .clk(clk), .rst(rst),
        .mem_inst(t_inst), .mem_ALUOUT(t_addr), .mem_RFRD2(t_wd),
        .mem_MemRead(t_rd), .mem_MemWrite(t_wr),
        .stall(stall_t), .rd_data(rd_data_t), .rd_valid(rd_valid_t),
        .misalign(misalign_t), .bus_err(bus_err_t),
        .dm_req(dm_req_t), .dm_we(dm_we_t), .dm_addr(dm_addr_t),
        .dm_wdata(dm_wdata_t), .dm_be(dm_be_t),
        .dm_ack(t_ack), .dm_rdata(t_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on the main DUT; ack arrives in REQ cycle ack_at (1 = first).
    task automatic run_access(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                              input logic [31:0] st_data, input logic rd, input logic wr,
                              input logic [31:0] rdata, input int ack_at,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_valid,
                              input logic [31:0] exp_rd);
        int   stalls;
        logic stable;
        @(negedge clk);
        mem_inst = inst; mem_ALUOUT = addr; mem_RFRD2 = st_data;
        mem_MemRead = rd; mem_MemWrite = wr;
        #1;
        stalls = stall ? 1 : 0;
        stable = 1'b1;
        for (int k = 1; k <= ack_at; k++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (!(dm_req === 1'b1 && dm_we === wr && dm_addr === exp_addr &&
                  dm_be === exp_be && dm_wdata === exp_wdata))
                stable = 1'b0;
            if (k == ack_at) begin
                dm_ack = 1'b1;
                dm_rdata = rdata;
            end
        end
        @(negedge clk);
        dm_ack = 1'b0;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
        #1;
        check_eq({tag, " bus_fields"}, {31'b0, stable}, 32'd1);
        check_eq({tag, " stall_cycles"}, stalls, ack_at + 1);
        check_eq({tag, " done_stall"}, {31'b0, stall}, 32'd0);
        check_eq({tag, " done_req"}, {31'b0, dm_req}, 32'd0);
        check_eq({tag, " rd_valid"}, {31'b0, rd_valid}, {31'b0, exp_valid});
        check_eq({tag, " rd_data"}, rd_data, exp_rd);
        @(negedge clk);
        #1;
        check_eq({tag, " rd_valid_after"}, {31'b0, rd_valid}, 32'd0);
    endtask

    task automatic run_misalign(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                                input logic rd, input logic wr);
        @(negedge clk);
        mem_inst = inst; mem_ALUOUT = addr; mem_RFRD2 = 32'h11223344;
        mem_MemRead = rd; mem_MemWrite = wr;
        #1;
        check_eq({tag, " stall"}, {31'b0, stall}, 32'd0);
        @(negedge clk);
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
        #1;
        check_eq({tag, " misalign"}, {31'b0, misalign}, 32'd1);
        check_eq({tag, " no_req"}, {31'b0, dm_req}, 32'd0);
        @(negedge clk);
        #1;
        check_eq({tag, " misalign_after"}, {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        int n_req;
        rst = 1'b1;
        mem_inst = '0; mem_ALUOUT = '0; mem_RFRD2 = '0;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
        dm_ack = 1'b0; dm_rdata = '0;
        t_inst = '0; t_addr = '0; t_wd = '0; t_rd = 1'b0; t_wr = 1'b0;
        t_ack = 1'b0; t_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset dm_req", {31'b0, dm_req}, 32'd0);
        check_eq("reset stall", {31'b0, stall}, 32'd0);
        check_eq("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        check_eq("reset rd_data", rd_data, 32'd0);
        check_eq("reset dm_be", {28'b0, dm_be}, 32'd0);
        check_eq("reset dm_addr", dm_addr, 32'd0);
        check_eq("reset misalign", {31'b0, misalign}, 32'd0);
        check_eq("reset bus_err", {31'b0, bus_err}, 32'd0);
        rst = 1'b0;

        //          tag    inst          addr          st_data       rd wr rdata         ack addr          be       wdata         vld exp_rd
        run_access("lw",  32'h8C000000, 32'h00000010, 32'h0,        1, 0, 32'hDEADBEEF, 1, 32'h00000010, 4'b1111, 32'h0,        1, 32'hDEADBEEF);
        run_access("lb",  32'h80000000, 32'h00000013, 32'h0,        1, 0, 32'h80FF0000, 1, 32'h00000010, 4'b1111, 32'h0,        1, 32'hFFFFFF80);
        run_access("lbu", 32'h90000000, 32'h00000013, 32'h0,        1, 0, 32'h80FF0000, 2, 32'h00000010, 4'b1111, 32'h0,        1, 32'h00000080);
        run_access("lh",  32'h84000000, 32'h00000012, 32'h0,        1, 0, 32'h80FF0000, 1, 32'h00000010, 4'b1111, 32'h0,        1, 32'hFFFF80FF);
        run_access("lhu", 32'h94000000, 32'h00000010, 32'h0,        1, 0, 32'h1234F00D, 1, 32'h00000010, 4'b1111, 32'h0,        1, 32'h0000F00D);
        run_access("sh",  32'hA4000000, 32'h00000022, 32'h1234ABCD, 0, 1, 32'h0,        5, 32'h00000020, 4'b1100, 32'hABCDABCD, 0, 32'h0000F00D);
        run_access("sb",  32'hA0000000, 32'h00000031, 32'h000000A5, 0, 1, 32'h0,        1, 32'h00000030, 4'b0010, 32'hA5A5A5A5, 0, 32'h0000F00D);

        run_misalign("lw_mis", 32'h8C000000, 32'h00000006, 1, 0);
        run_misalign("sh_mis", 32'hA4000000, 32'h00000003, 0, 1);

        // An ack with no transaction pending must be ignored.
        @(negedge clk);
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        check_eq("stray_ack rd_valid", {31'b0, rd_valid}, 32'd0);
        check_eq("stray_ack rd_data", rd_data, 32'h0000F00D);
        dm_ack = 1'b0;

        // Timeout: lw with no ack on the TIMEOUT=4 instance.
        @(negedge clk);
        t_inst = 32'h8C000000; t_addr = 32'h00000040; t_rd = 1'b1;
        #1;
        check_eq("to issue_stall", {31'b0, stall_t}, 32'd1);
        n_req = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (dm_req_t) n_req++;
            else break;
        end
        check_eq("to req_cycles", n_req, 32'd5);
        check_eq("to bus_err", {31'b0, bus_err_t}, 32'd1);
        check_eq("to stall_released", {31'b0, stall_t}, 32'd0);
        check_eq("to rd_valid", {31'b0, rd_valid_t}, 32'd0);
        t_rd = 1'b0;
        @(negedge clk);
        #1;
        check_eq("to bus_err_after", {31'b0, bus_err_t}, 32'd0);
        check_eq("to rd_data_kept", rd_data_t, 32'd0);

        // Reset during the second REQ cycle of a load.
        @(negedge clk);
        mem_inst = 32'h8C000000; mem_ALUOUT = 32'h00000030; mem_MemRead = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst pre_req", {31'b0, dm_req}, 32'd1);
        rst = 1'b1;
        mem_MemRead = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst dm_req", {31'b0, dm_req}, 32'd0);
        check_eq("rst stall", {31'b0, stall}, 32'd0);
        check_eq("rst rd_valid", {31'b0, rd_valid}, 32'd0);
        check_eq("rst bus_err", {31'b0, bus_err}, 32'd0);
        rst = 1'b0;
        run_access("sw",  32'hAC000000, 32'h00000044, 32'hCAFEF00D, 0, 1, 32'h0,        2, 32'h00000044, 4'b1111, 32'hCAFEF00D, 0, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs (mem_inst, mem_ALUOUT, mem_RFRD2, mem_MemRead, mem_MemWrite).
- Turns each load or store into a req/ack transaction on a variable-latency data-memory bus.
- Stalls the pipeline until the access completes.
- Formats load data (lb/lbu/lh/lhu/lw), generates byte enables for stores (sb/sh/sw), and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: max cycles in REQ waiting for dm_ack before aborting.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mem_inst  in  32  instruction in MEM; opcode = [31:26]
- mem_ALUOUT  in  32  effective byte address
- mem_RFRD2  in  32  store data
- mem_MemRead  in  1  load in MEM
- mem_MemWrite  in  1  store in MEM
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; combinational
- rd_data  out  32  formatted load data, registered
- rd_valid  out  1  one-cycle pulse; rd_data valid
- misalign  out  1  one-cycle pulse; access not issued
- bus_err  out  1  one-cycle pulse; timeout abort
- dm_req  out  1  bus request, registered
- dm_we  out  1  1 = write
- dm_addr  out  32  word address {ALUOUT[31:2],2'b00}
- dm_wdata  out  32  lane-replicated store data
- dm_be  out  4  byte enables (bit i = byte lane i, little-endian)
- dm_ack  in  1  bus completion; dm_rdata valid in the same cycle
- dm_rdata  in  32  read word

Behaviour:
- Reset values: state=IDLE, all outputs 0, counter 0. Synchronous reset mid-transaction aborts it; dm_req is 0 from the next cycle; no rd_valid or bus_err pulse.
- Opcode decode:
  - 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw.
  - Any other opcode with MemRead or MemWrite set is treated as a word access.
  - MemRead and MemWrite both set: treated as a write.
- Access is defined as access = mem_MemRead | mem_MemWrite.
- Alignment:
  - Word accesses require addr[1:0]=0; halfword accesses require addr[0]=0.
  - A misaligned access in IDLE pulses misalign for one cycle, issues no request, and keeps stall=0.
- States:
  - IDLE → REQ on an aligned access. Latch addr, we, be, wdata, byte offset and load type; load dm_req=1; clear counter.
  - REQ: hold dm_req and all dm_* outputs stable until dm_ack.
    - On dm_ack: capture formatted rd_data (loads only) and go to DONE.
    - On counter==TIMEOUT without ack: go to DONE with bus_err pending.
    - Otherwise increment the counter.
  - DONE: lasts exactly one cycle. dm_req=0. rd_valid=1 for loads, or bus_err=1 on timeout. Then → IDLE unconditionally.
- Stall: stall = (IDLE & access & aligned) | REQ. Stall is 0 in DONE, so the pipeline advances at the end of DONE. IDLE never re-issues the completed instruction.
- Minimum latency is ack in the first REQ cycle: 2 stall cycles, then 1 DONE cycle.
- Store formatting:
  - sb: wdata={4{RFRD2[7:0]}}, be=1<<addr[1:0].
  - sh: wdata={2{RFRD2[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - sw: wdata=RFRD2, be=4'b1111.
  - For loads: be=4'b1111, wdata=0.
- Load formatting: select byte or halfword by the latched offset. lb/lh sign-extend; lbu/lhu zero-extend. Stores leave rd_data unchanged.
- dm_ack outside REQ is ignored.
- On timeout, rd_data keeps its previous value and rd_valid stays 0.

Decomposition:
- Shared package mips_mem_pkg:
  - Opcode constants OP_LB..OP_SW.
  - Enum for access size/sign {SZ_B, SZ_BU, SZ_H, SZ_HU, SZ_W}.
  - Enum for FSM state {ST_IDLE, ST_REQ, ST_DONE}.
- One sub-module: dmem_lane_fmt, purely combinational. It performs the store lane replication, byte-enable generation and load extract/extend.

Test Plan:
- lw, addr 0x0000_0010, dm_ack on the 1st REQ cycle, dm_rdata 0xDEADBEEF → dm_addr 0x10, be 1111, stall 2 cycles, rd_valid pulse with rd_data 0xDEADBEEF.
- lb at 0x13 with dm_rdata 0x80FF_0000 → rd_data 0xFFFFFF80. lbu at the same address → 0x00000080. lh at 0x12 → 0xFFFF80FF.
- sh, addr 0x22, RFRD2 0x1234ABCD, ack after 5 cycles → dm_we=1, be 1100, wdata 0xABCDABCD, stable for all 5 cycles; stall for 6 cycles; no rd_valid.
- lw at 0x06 → misalign pulse, dm_req stays 0, stall 0. sh at 0x03 → misalign pulse.
- TIMEOUT=4, no ack → dm_req high for 5 REQ cycles, then bus_err pulse in DONE and stall released.
- rst asserted in the 2nd REQ cycle → next cycle dm_req=0, stall=0, no pulses. A following aligned sw starts a fresh transaction.
